imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts byte addresses from the PC/fetch logic and returns 32-bit instruction words.
- Returns each word a fixed number of cycles later, using a valid/ready handshake on both request and response.
- Replaces the single-cycle combinational instruction memory when the fetch stage is moved to a pipelined, stallable model.
- Includes a write port for program preload from the bench or a loader.

Parameters:
- ADDR_W, 5, byte-address width; matches the PC width.
- LATENCY, 2, cycles from request acceptance to response visibility; legal range 1..8.
- QDEPTH, 4, maximum outstanding requests; must be ≥ LATENCY for full throughput; power of two.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  ADDR_W  byte address (the PC)
- resp_valid  out  1  response word available
- resp_ready  in  1  fetch side consumes the response
- resp_instr  out  32  instruction word
- resp_addr  out  ADDR_W  address the response belongs to
- resp_err  out  1  misaligned request (req_addr[1:0] != 0)
- prog_we  in  1  preload write enable
- prog_addr  in  ADDR_W  preload byte address; bits [1:0] ignored
- prog_data  in  32  preload word

Behaviour:
- Memory: 2^(ADDR_W-2) words, indexed by addr[ADDR_W-1:2]. Contents are not reset and are retained across reset.
- Accept: on an edge where req_valid && req_ready.
  - At that edge the word is read and captured together with addr and the err flag.
  - Address wrap-around is implicit through truncation to ADDR_W bits.
- Misaligned request:
  - resp_err=1 and resp_instr=32'h0.
  - The request still consumes a slot and still returns in order.
- Read/write collision: a prog_we to the same word on the accepting edge returns the OLD data. The write takes effect afterwards.
- Latency pipeline:
  - A delay line of LATENCY-1 stages, each with a valid bit, feeds the response FIFO (QDEPTH entries).
  - An entry accepted at edge k is written into the FIFO at edge k+LATENCY-1. resp_valid is therefore visible in the cycle after that edge.
  - For LATENCY=1 the FIFO is written directly at the accepting edge.
- Outstanding counter (0..QDEPTH):
  - +1 on accept; -1 on response handshake (resp_valid && resp_ready); both together leave it unchanged.
  - req_ready = (outstanding < QDEPTH), combinational from registered state. It does not depend on resp_ready in the same cycle.
  - This guarantees the FIFO never overflows.
- Response:
  - resp_valid = FIFO not empty. resp_instr, resp_addr and resp_err come from the FIFO head, forced to 0 while resp_valid=0.
  - The head pops on resp_valid && resp_ready.
  - While resp_ready=0, the head and all outputs hold stable.
- Ordering: strictly in order.
- Throughput: 1 response per cycle when resp_ready stays high and QDEPTH ≥ LATENCY.
- Reset (asynchronous, also mid-operation):
  - Clears delay-line valids, FIFO pointers and the outstanding counter.
  - In-flight requests are dropped.
  - resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0, req_ready=1 (after reset).

Optional Feature:
- Macro: IMEM_STATS_EN.
- With the macro defined, two outputs are added:
  - stall_cnt [15:0]: counts cycles with req_valid && !req_ready; saturates at 16'hFFFF; cleared by reset.
  - resp_cnt [15:0]: counts response handshakes; wraps.
- Without the macro, both ports and their logic are absent and the remaining behaviour is identical.

Decomposition:
- Package imem_pkg holds:
  - Typedef imem_resp_t struct {instr[31:0], addr, err}.
  - Constants WORD_BYTES=4 and INSTR_ZERO=32'h0.
  - Parameter-legality checks as elaboration-time asserts.
- One natural sub-module: imem_resp_fifo, a parameterized synchronous FIFO of imem_resp_t with asynchronous reset, push/pop, empty/full and count.

Test Plan:
- Preload words 0..7 with 32'h1000_0000+i; issue addresses 0,4,8 back-to-back with resp_ready=1 → responses 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, each 2 cycles after its accept, on consecutive cycles.
- Hold resp_ready=0 and issue 6 requests → exactly 4 accepted, req_ready=0 thereafter; outputs hold the addr-0 word. Raise resp_ready → 4 responses in order, then req_ready=1.
- Request addr 5'd6 → resp_err=1, resp_instr=0, resp_addr=6; the next aligned request returns normally.
- prog_we writes 32'hDEAD_BEEF to addr 12 on the same edge a request to 12 is accepted → response is the old word; a second request returns 32'hDEAD_BEEF.
- Assert reset with 3 requests in flight → resp_valid=0 immediately, outstanding=0, no stale response after release; memory contents unchanged.
- With IMEM_STATS_EN: 5 blocked request cycles → stall_cnt=5; 3 handshakes → resp_cnt=3.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction-memory responder.
// Holds the response-entry struct plus parameter legality helpers used at elaboration.
package imem_pkg;

    localparam int          WORD_BYTES    = 4;
    localparam logic [31:0] INSTR_ZERO    = 32'h0;
    // Widest byte address an entry can carry; narrower instances zero-extend into it.
    localparam int          IMEM_ADDR_MAX = 16;

    typedef struct packed {
        logic [31:0]              instr;
        logic [IMEM_ADDR_MAX-1:0] addr;
        logic                     err;
    } imem_resp_t;

    function automatic bit imem_is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit imem_params_ok(input int addr_w, input int latency, input int qdepth);
        return (addr_w > $clog2(WORD_BYTES)) && (addr_w <= IMEM_ADDR_MAX) &&
               (latency >= 1) && (latency <= 8) && imem_is_pow2(qdepth);
    endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Synchronous FIFO of imem_resp_t entries: head visible combinationally, push lands next cycle.
// Push while full is dropped unless a pop frees the slot on the same edge; pop while empty is ignored.
module imem_resp_fifo
    import imem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  imem_resp_t       i_push_dat,
    input  logic             i_pop,
    output imem_resp_t       o_pop_dat,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    imem_resp_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_count   = r_cnt;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: word read at accept, response visible LATENCY cycles later, strictly in order.
// req_ready drops once QDEPTH requests are outstanding; resp_ready=0 freezes the head. IMEM_STATS_EN adds stall/response counters.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err,
`ifdef IMEM_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       resp_cnt,
`endif
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data
);

    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int WORDS = 1 << IDX_W;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    generate
        if (!imem_params_ok(ADDR_W, LATENCY, QDEPTH)) begin : g_bad_params
            $error("imem_responder: illegal ADDR_W/LATENCY/QDEPTH combination");
        end
    endgenerate

    logic [31:0]      r_mem [WORDS];
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_acc;
    logic             w_req_err;
    imem_resp_t       w_req_ent;
    logic             w_push;
    imem_resp_t       w_push_ent;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_fifo_cnt;
    imem_resp_t       w_head;
    logic [CNT_W-1:0] r_outst;
    logic             w_unused;

    assign w_rd_idx  = req_addr[ADDR_W-1:OFF_W];
    assign w_wr_idx  = prog_addr[ADDR_W-1:OFF_W];
    assign w_req_err = |req_addr[OFF_W-1:0];
    assign req_ready = (r_outst < CNT_W'(QDEPTH));
    assign w_acc     = req_valid && req_ready;

    // Program memory has no reset so a preloaded image survives a core reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[w_wr_idx] <= prog_data;
        end
    end

    // Read sees pre-edge contents, so a same-edge preload write to this word returns old data.
    always_comb begin
        w_req_ent       = '0;
        w_req_ent.err   = w_req_err;
        w_req_ent.addr  = IMEM_ADDR_MAX'(req_addr);
        w_req_ent.instr = w_req_err ? INSTR_ZERO : r_mem[w_rd_idx];
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push     = w_acc;
            assign w_push_ent = w_req_ent;
        end else begin : g_dline
            localparam int STAGES = LATENCY - 1;
            logic [STAGES-1:0] r_dl_vld;
            imem_resp_t        r_dl_ent [STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dl_vld <= '0;
                end else begin
                    r_dl_vld[0] <= w_acc;
                    for (int i = 1; i < STAGES; i++) begin
                        r_dl_vld[i] <= r_dl_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_dl_ent[0] <= w_req_ent;
                for (int i = 1; i < STAGES; i++) begin
                    r_dl_ent[i] <= r_dl_ent[i-1];
                end
            end

            assign w_push     = r_dl_vld[STAGES-1];
            assign w_push_ent = r_dl_ent[STAGES-1];
        end
    endgenerate

    imem_resp_fifo #(
        .DEPTH (QDEPTH)
    ) u_resp_fifo (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (w_fifo_cnt)
    );

    // Counting delay-line and FIFO entries together is what keeps the FIFO from overflowing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    assign resp_valid = !w_empty;
    assign w_pop      = resp_valid && resp_ready;
    assign resp_instr = resp_valid ? w_head.instr : INSTR_ZERO;
    assign resp_addr  = resp_valid ? w_head.addr[ADDR_W-1:0] : '0;
    assign resp_err   = resp_valid ? w_head.err : 1'b0;

`ifdef IMEM_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_resp_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_resp_cnt  <= '0;
        end else begin
            if (req_valid && !req_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_pop) begin
                r_resp_cnt <= r_resp_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign resp_cnt  = r_resp_cnt;
`endif

    assign w_unused = ^{prog_addr[OFF_W-1:0], w_head.addr, w_fifo_cnt, w_full};

endmodule

// File: tb/tb_imem_responder.sv
// Directed plus random stimulus against a queue-based reference model of the responder.
// Model: FIFO of expected responses, each tagged with the cycle it becomes visible.
module tb_imem_responder;

    localparam int ADDR_W = 5;
    localparam int LAT    = 2;
    localparam int QD     = 4;
    localparam int WORDS  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [31:0]       resp_instr;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_err;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [31:0]       prog_data = '0;
`ifdef IMEM_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       resp_cnt;
`endif

    imem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LAT),
        .QDEPTH  (QD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
`ifdef IMEM_STATS_EN
        .stall_cnt  (stall_cnt),
        .resp_cnt   (resp_cnt),
`endif
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
        int                due;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mmem [WORDS];
    logic [37:0] hs_log[$];
    int          hs_n[$];
    int          total = 0;
    int          bad = 0;
    int          n = 0;
    int          acc_obs = 0;
    int          m_stall = 0;
    logic [15:0] m_resp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (expq.size() > 0) && (expq[0].due <= n);
        chk("resp_valid", 64'(resp_valid), 64'(ev));
        chk("req_ready", 64'(req_ready), 64'(expq.size() < QD));
        if (ev) begin
            chk("resp_instr", 64'(resp_instr), 64'(expq[0].instr));
            chk("resp_addr", 64'(resp_addr), 64'(expq[0].addr));
            chk("resp_err", 64'(resp_err), 64'(expq[0].err));
        end else begin
            chk("idle_instr", 64'(resp_instr), 64'h0);
            chk("idle_addr_err", 64'({resp_addr, resp_err}), 64'h0);
        end
`ifdef IMEM_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("resp_cnt", 64'(resp_cnt), 64'(m_resp));
`endif
    endtask

    // One cycle: check outputs at the negedge, drive the next inputs, advance the model across the posedge.
    task automatic step(input logic rv, input logic [ADDR_W-1:0] ra, input logic rr,
                        input logic pw = 1'b0, input logic [ADDR_W-1:0] pa = '0,
                        input logic [31:0] pd = '0);
        logic ev;
        logic er;
        exp_t e;
        check_outputs();
        ev = (expq.size() > 0) && (expq[0].due <= n);
        er = (expq.size() < QD);
        req_valid  = rv;
        req_addr   = ra;
        resp_ready = rr;
        prog_we    = pw;
        prog_addr  = pa;
        prog_data  = pd;
        if (resp_valid && rr) begin
            hs_log.push_back({resp_err, resp_addr, resp_instr});
            hs_n.push_back(n);
        end
        if (rv && req_ready) acc_obs++;
        if (rv && !er && m_stall < 65535) m_stall++;
        if (ev && rr) begin
            void'(expq.pop_front());
            m_resp = m_resp + 16'd1;
        end
        if (rv && er) begin
            e.addr  = ra;
            e.err   = (ra[1:0] != 2'b00);
            e.instr = e.err ? 32'h0 : mmem[ra[ADDR_W-1:2]];
            e.due   = n + LAT;
            expq.push_back(e);
        end
        if (pw) mmem[pa[ADDR_W-1:2]] = pd;
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && expq.size() > 0; i++) step(1'b0, '0, 1'b1);
        chk("drain_valid", 64'(resp_valid), 64'h0);
        chk("drain_ready", 64'(req_ready), 64'h1);
    endtask

    task automatic clear_log();
        hs_log.delete();
        hs_n.delete();
    endtask

    initial begin
        int n0;
        @(negedge clk);
        chk("rst_valid", 64'(resp_valid), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'h1);
        chk("rst_instr", 64'(resp_instr), 64'h0);
        chk("rst_addr_err", 64'({resp_addr, resp_err}), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < WORDS; i++) step(1'b0, '0, 1'b0, 1'b1, 5'(i * 4), 32'h1000_0000 + 32'(i));

        // Back-to-back fetches: two cycles to first response, then one per cycle.
        clear_log();
        n0 = n;
        step(1'b1, 5'd0, 1'b1);
        step(1'b1, 5'd4, 1'b1);
        step(1'b1, 5'd8, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        chk("t1_count", 64'(hs_log.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk("t1_word", 64'(hs_log[k][31:0]), 64'(32'h1000_0000 + 32'(k)));
        chk("t1_first_latency", 64'(hs_n[0] - n0), 64'd2);
        chk("t1_consecutive", 64'(hs_n[2] - hs_n[0]), 64'd2);

        // Backpressure: only QD requests get in while the consumer stalls.
        clear_log();
        acc_obs = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 5'(i * 4), 1'b0);
        chk("t2_accepted", 64'(acc_obs), 64'd4);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t2_blocked_ready", 64'(req_ready), 64'h0);
        chk("t2_hold_word", 64'(resp_instr), 64'h1000_0000);
        repeat (6) step(1'b0, '0, 1'b1);
        chk("t2_count", 64'(hs_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk("t2_order", 64'(hs_log[k][31:0]), 64'(32'h1000_0000 + 32'(k)));
        chk("t2_ready_back", 64'(req_ready), 64'h1);

        // Misaligned request followed by an aligned one.
        clear_log();
        step(1'b1, 5'd6, 1'b1);
        step(1'b1, 5'd8, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        chk("t3_err_resp", 64'(hs_log[0]), 64'({1'b1, 5'd6, 32'h0}));
        chk("t3_next_ok", 64'(hs_log[1]), 64'({1'b0, 5'd8, 32'h1000_0002}));

        // Same-edge preload write and fetch of word 3.
        clear_log();
        step(1'b1, 5'd12, 1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF);
        step(1'b1, 5'd12, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        chk("t4_old_data", 64'(hs_log[0][31:0]), 64'h1000_0003);
        chk("t4_new_data", 64'(hs_log[1][31:0]), 64'hDEAD_BEEF);

        repeat (400) begin
            step(1'($urandom % 2), 5'($urandom_range(0, 31)), 1'(($urandom % 4) != 0),
                 1'(($urandom % 8) == 0), 5'($urandom_range(0, 31)), $urandom);
        end
        drain();

        // Asynchronous reset with three requests in flight.
        step(1'b1, 5'd0, 1'b0);
        step(1'b1, 5'd4, 1'b0);
        step(1'b1, 5'd8, 1'b0);
        req_valid = 1'b0;
        chk("pre_rst_valid", 64'(resp_valid), 64'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'h0);
        chk("mid_rst_instr", 64'(resp_instr), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h1);
        expq.delete();
        m_stall = 0;
        m_resp  = '0;
        @(posedge clk);
        n++;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) step(1'b0, '0, 1'b1);

`ifdef IMEM_STATS_EN
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i * 4), 1'b0);
        repeat (5) step(1'b1, 5'd16, 1'b0);
        chk("stats_stall5", 64'(stall_cnt), 64'd5);
        repeat (3) step(1'b0, '0, 1'b1);
        chk("stats_resp3", 64'(resp_cnt), 64'd3);
        drain();
`endif

        for (int i = 0; i < WORDS; i++) step(1'b1, 5'(i * 4), 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
